// File: rtl/conversion_sequencer.sv
// conversion_sequencer: phase controller for the dual-slope voltmeter.
// Sequences auto-zero, fixed-length integrate and deintegrate phases, drives
// the front-end switch selects and the 12-bit measurement counter, captures
// the counter value at the comparator zero crossing and flags overrange.
// Optional feature macro: CONV_AUTOZERO_EN (defined = AUTOZERO phase present,
// undefined = start goes straight to INTEGRATE and autozero_o is tied low).
module conversion_sequencer #(
  parameter int unsigned AUTOZERO_CYCLES = 256,
  parameter int unsigned INTEG_CYCLES    = 2048
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        comparator_i,
  input  logic [11:0] measurement_count_i,
  output logic        measurement_en_o,
  output logic        measurement_clear_o,
  output logic        autozero_o,
  output logic        integrate_sel_o,
  output logic        deintegrate_sel_o,
  output logic        busy_o,
  output logic [11:0] result_o,
  output logic        result_valid_o,
  output logic        overrange_o
);

  localparam logic [11:0] FULL_SCALE = 12'hFFF;
  localparam logic [11:0] INTEG_LAST = 12'(INTEG_CYCLES - 1);

  // Out-of-range phase lengths cannot be timed by the 12-bit phase timer.
  if (AUTOZERO_CYCLES < 1 || AUTOZERO_CYCLES > 4095) begin : g_bad_autozero_cycles
    $error("AUTOZERO_CYCLES must be in 1..4095");
  end
  if (INTEG_CYCLES < 1 || INTEG_CYCLES > 4095) begin : g_bad_integ_cycles
    $error("INTEG_CYCLES must be in 1..4095");
  end

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
`ifdef CONV_AUTOZERO_EN
    AUTOZERO    = 2'd1,
`endif
    INTEGRATE   = 2'd2,
    DEINTEGRATE = 2'd3
  } state_t;

`ifdef CONV_AUTOZERO_EN
  localparam logic [11:0] AUTOZERO_LAST = 12'(AUTOZERO_CYCLES - 1);
`endif

  state_t      state;
  state_t      next_state;
  logic [11:0] timer;
  logic        count_full;
  logic        capture;
  logic        over_hit;
  logic        start_accept;

  assign count_full = (measurement_count_i == FULL_SCALE);

  // Next-state decode plus the combinational counter controls and capture strobes.
  always_comb begin
    next_state   = state;
    start_accept = 1'b0;
    capture      = 1'b0;
    over_hit     = 1'b0;
    measurement_en_o    = 1'b0;
    measurement_clear_o = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          start_accept        = 1'b1;
          measurement_clear_o = 1'b1;
`ifdef CONV_AUTOZERO_EN
          next_state = AUTOZERO;
`else
          next_state = INTEGRATE;
`endif
        end
      end
`ifdef CONV_AUTOZERO_EN
      AUTOZERO: begin
        if (timer == AUTOZERO_LAST) next_state = INTEGRATE;
      end
`endif
      INTEGRATE: begin
        if (timer == INTEG_LAST) next_state = DEINTEGRATE;
      end
      DEINTEGRATE: begin
        measurement_en_o = comparator_i && !count_full;
        if (!comparator_i) begin
          capture    = 1'b1;
          next_state = IDLE;
        end else if (count_full) begin
          over_hit   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register and phase timer; the timer restarts from 0 on every state entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      timer <= 12'd0;
    end else begin
      state <= next_state;
      if (next_state != state || state == IDLE) timer <= 12'd0;
      else timer <= timer + 12'd1;
    end
  end

  // Registered switch selects and busy flag, decoded from the upcoming state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      integrate_sel_o   <= 1'b0;
      deintegrate_sel_o <= 1'b0;
      busy_o            <= 1'b0;
    end else begin
      integrate_sel_o   <= (next_state == INTEGRATE);
      deintegrate_sel_o <= (next_state == DEINTEGRATE);
      busy_o            <= (next_state != IDLE);
    end
  end

`ifdef CONV_AUTOZERO_EN
  // Auto-zero switch select, registered like the other phase selects.
  always_ff @(posedge clk_i) begin
    if (rst_i) autozero_o <= 1'b0;
    else autozero_o <= (next_state == AUTOZERO);
  end
`else
  assign autozero_o = 1'b0;
`endif

  // Result capture, one-cycle valid pulse and sticky overrange flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o       <= 12'd0;
      result_valid_o <= 1'b0;
      overrange_o    <= 1'b0;
    end else begin
      result_valid_o <= capture || over_hit;
      if (capture) result_o <= measurement_count_i;
      else if (over_hit) result_o <= FULL_SCALE;
      if (start_accept) overrange_o <= 1'b0;
      else if (over_hit) overrange_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conversion_sequencer.sv
// Testbench for conversion_sequencer: table-driven conversions against a
// bench-side model of the 12-bit measurement counter, plus hand-written
// reset and overrange-clear sequences.
module tb_conversion_sequencer;

  localparam int A = 4;
  localparam int I = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic        comparator;
  logic [11:0] measCount;
  logic        measEn;
  logic        measClear;
  logic        autozero;
  logic        integSel;
  logic        deintSel;
  logic        busy;
  logic [11:0] result;
  logic        resultValid;
  logic        overrange;

  int vectors;
  int miscompares;
  logic [11:0] prevResult;
  logic        prevOver;

  typedef struct {
    int         highCycles;
    bit         holdHigh;
    bit         startInInteg;
    logic [11:0] expResult;
    bit         expOver;
  } vec_t;

  vec_t vecs[8];

  conversion_sequencer #(
    .AUTOZERO_CYCLES(A),
    .INTEG_CYCLES(I)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .comparator_i(comparator),
    .measurement_count_i(measCount),
    .measurement_en_o(measEn),
    .measurement_clear_o(measClear),
    .autozero_o(autozero),
    .integrate_sel_o(integSel),
    .deintegrate_sel_o(deintSel),
    .busy_o(busy),
    .result_o(result),
    .result_valid_o(resultValid),
    .overrange_o(overrange)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the external 12-bit measurement counter driven by the DUT controls.
  always @(posedge clk) begin
    if (rst || measClear) measCount <= 12'd0;
    else if (measEn) measCount <= measCount + 12'd1;
  end

  // Single comparison: counts it and reports a miscompare.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one full conversion and checks every phase against the vector.
  task automatic applyStimulus(input vec_t v);
    bit ok;
    int endJ;
    // request
    @(negedge clk);
    start = 1'b1;
    #1;
    checkOutput("clear_on_start", measClear, 1);
    checkOutput("idle_not_busy", busy, 0);
    checkOutput("overrange_held_to_start", overrange, prevOver);
    checkOutput("result_held_to_start", result, prevResult);
    @(posedge clk);
`ifdef CONV_AUTOZERO_EN
    ok = 1'b1;
    for (int c = 1; c <= A; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (c == 1) checkOutput("overrange_cleared", overrange, 0);
      ok &= autozero && !integSel && !deintSel && busy && !measEn && !measClear && !resultValid;
    end
    checkOutput("autozero_phase", ok, 1);
`endif
    ok = 1'b1;
    for (int c = 1; c <= I; c++) begin
      @(negedge clk);
      start = v.startInInteg && (c == 3);
      #1;
`ifndef CONV_AUTOZERO_EN
      if (c == 1) checkOutput("overrange_cleared", overrange, 0);
`endif
      ok &= integSel && !autozero && !deintSel && busy && !measEn && !measClear && !resultValid;
    end
    checkOutput("integrate_phase", ok, 1);
    endJ = v.holdHigh ? 4095 : v.highCycles;
    ok = 1'b1;
    for (int j = 0; j <= endJ; j++) begin
      @(negedge clk);
      start = 1'b0;
      comparator = v.holdHigh || (j < v.highCycles);
      #1;
      ok &= deintSel && !integSel && !autozero && busy && !resultValid && !measClear
            && (measCount == 12'(j)) && (measEn == (comparator && j != 4095));
    end
    checkOutput("deintegrate_phase", ok, 1);
    @(negedge clk);
    comparator = 1'b0;
    #1;
    checkOutput("valid_pulse", resultValid, 1);
    checkOutput("busy_fall", busy, 0);
    checkOutput("deint_off", deintSel, 0);
    checkOutput("result", result, v.expResult);
    checkOutput("overrange", overrange, v.expOver);
    @(negedge clk);
    #1;
    checkOutput("valid_one_cycle", resultValid, 0);
    checkOutput("result_hold", result, v.expResult);
    checkOutput("overrange_hold", overrange, v.expOver);
    prevResult = v.expResult;
    prevOver   = v.expOver;
  endtask

  initial begin
    bit ok;
    vectors     = 0;
    miscompares = 0;
    prevResult  = 12'd0;
    prevOver    = 1'b0;
    rst         = 1'b1;
    start       = 1'b0;
    comparator  = 1'b0;

    //           high  hold start expResult expOver
    vecs[0] = '{1000, 1'b0, 1'b0, 12'd1000, 1'b0};
    vecs[1] = '{0,    1'b0, 1'b0, 12'd0,    1'b0};
    vecs[2] = '{1,    1'b0, 1'b0, 12'd1,    1'b0};
    vecs[3] = '{5,    1'b0, 1'b1, 12'd5,    1'b0};
    vecs[4] = '{4094, 1'b0, 1'b0, 12'd4094, 1'b0};
    vecs[5] = '{4095, 1'b0, 1'b0, 12'd4095, 1'b0};
    vecs[6] = '{0,    1'b1, 1'b0, 12'hFFF,  1'b1};
    vecs[7] = '{7,    1'b0, 1'b0, 12'd7,    1'b0};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_valid", resultValid, 0);
    checkOutput("rst_overrange", overrange, 0);
    checkOutput("rst_selects", {autozero, integSel, deintSel}, 0);
    checkOutput("rst_counter_ctl", {measEn, measClear}, 0);
    rst = 1'b0;

    for (int n = 0; n < 8; n++) applyStimulus(vecs[n]);

    // Reset in DEINTEGRATE aborts without a result and clears the held result.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    comparator = 1'b1;
`ifdef CONV_AUTOZERO_EN
    repeat (A) @(negedge clk);
`endif
    repeat (I + 5) @(negedge clk);
    #1;
    checkOutput("pre_abort_deint", deintSel, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_selects", {autozero, integSel, deintSel}, 0);
    checkOutput("abort_result", result, 0);
    checkOutput("abort_valid", resultValid, 0);
    checkOutput("abort_counter_ctl", {measEn, measClear}, 0);
    rst = 1'b0;
    comparator = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      ok &= !resultValid && !busy;
    end
    checkOutput("abort_no_valid", ok, 1);
    prevResult = 12'd0;
    prevOver   = 1'b0;

    // Overrange then a fresh conversion: the new start clears the flag.
    applyStimulus(vecs[6]);
    applyStimulus(vecs[2]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
